// File: rtl/pc_btb_unit.sv
// pc_btb_unit: fetch PC generator with a direct-mapped BTB and 2-bit
// saturating direction counters. Resolved outcomes from execute train the
// BTB and, on a mispredict, redirect fetch and raise flush.
// Optional feature: define PC_BTB_PERF_EN to build the CTI / mispredict
// performance counters; otherwise both perf outputs are tied to zero.
module pc_btb_unit #(
    parameter int unsigned              ADDRESS_WIDTH = 32,
    parameter int unsigned              BTB_ENTRIES   = 16,
    parameter logic [ADDRESS_WIDTH-1:0] RESET_VECTOR  = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     trigger,
    input  logic                     stall_f,
    input  logic                     ex_valid,
    input  logic                     ex_is_cti,
    input  logic                     ex_taken,
    input  logic [ADDRESS_WIDTH-1:0] ex_pc,
    input  logic [ADDRESS_WIDTH-1:0] ex_target,
    input  logic                     ex_pred_taken,
    input  logic [ADDRESS_WIDTH-1:0] ex_pred_target,
    output logic [ADDRESS_WIDTH-1:0] pc,
    output logic [ADDRESS_WIDTH-1:0] pcplus4,
    output logic                     pred_taken,
    output logic [ADDRESS_WIDTH-1:0] pred_target,
    output logic                     flush,
    output logic [31:0]              perf_cti_count,
    output logic [31:0]              perf_mispredict_count
);

    localparam int unsigned IDX   = $clog2(BTB_ENTRIES);
    localparam int unsigned TAG_W = ADDRESS_WIDTH - IDX - 2;

    logic [BTB_ENTRIES-1:0]   valid_q;
    logic [TAG_W-1:0]         tag_mem [BTB_ENTRIES];
    logic [ADDRESS_WIDTH-1:0] tgt_mem [BTB_ENTRIES];
    logic [1:0]               ctr_mem [BTB_ENTRIES];

    logic [IDX-1:0]           f_idx;
    logic [TAG_W-1:0]         f_tag;
    logic                     f_hit;
    logic [IDX-1:0]           ex_idx;
    logic [TAG_W-1:0]         ex_tag;
    logic                     ex_hit;
    logic [ADDRESS_WIDTH-1:0] redirect;
    logic                     ctr_wr;
    logic                     tgt_wr;
    logic                     alloc;
    logic                     inval;
    logic [1:0]               ctr_cur;
    logic [1:0]               ctr_nxt;

    assign f_idx  = pc[IDX+1:2];
    assign f_tag  = pc[ADDRESS_WIDTH-1:IDX+2];
    assign ex_idx = ex_pc[IDX+1:2];
    assign ex_tag = ex_pc[ADDRESS_WIDTH-1:IDX+2];

    // Fetch-side lookup (sees pre-update contents) and mispredict detection
    always_comb begin
        pcplus4     = pc + ADDRESS_WIDTH'(4);
        f_hit       = valid_q[f_idx] && (tag_mem[f_idx] == f_tag);
        pred_taken  = f_hit && ctr_mem[f_idx][1];
        pred_target = pred_taken ? tgt_mem[f_idx] : pcplus4;
        ex_hit      = valid_q[ex_idx] && (tag_mem[ex_idx] == ex_tag);
        flush       = ex_valid &&
                      ((ex_taken != ex_pred_taken) ||
                       (ex_taken && (ex_pred_target != ex_target)));
        redirect    = ex_taken ? ex_target : (ex_pc + ADDRESS_WIDTH'(4));
    end

    // Decide the BTB write for the resolved execute instruction
    always_comb begin
        ctr_wr  = 1'b0;
        tgt_wr  = 1'b0;
        alloc   = 1'b0;
        inval   = 1'b0;
        ctr_cur = ctr_mem[ex_idx];
        ctr_nxt = ctr_cur;
        if (ex_valid) begin
            if (ex_is_cti) begin
                if (ex_hit) begin
                    ctr_wr = 1'b1;
                    tgt_wr = ex_taken;
                    if (ex_taken && (ctr_cur != 2'b11)) begin
                        ctr_nxt = ctr_cur + 2'd1;
                    end else if (!ex_taken && (ctr_cur != 2'b00)) begin
                        ctr_nxt = ctr_cur - 2'd1;
                    end
                end else if (ex_taken) begin
                    alloc   = 1'b1;
                    ctr_wr  = 1'b1;
                    tgt_wr  = 1'b1;
                    ctr_nxt = 2'b10;
                end
            end else if (ex_hit) begin
                inval = 1'b1;
            end
        end
    end

    // Next fetch PC: reset, redirect, hold, then prediction
    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= RESET_VECTOR;
        end else if (flush) begin
            pc <= redirect;
        end else if (trigger && !stall_f) begin
            pc <= pred_target;
        end
    end

    // Valid bits are the only BTB state that needs reset
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else if (alloc) begin
            valid_q[ex_idx] <= 1'b1;
        end else if (inval) begin
            valid_q[ex_idx] <= 1'b0;
        end
    end

    // Tag, target and counter storage; meaningless while the entry is invalid
    always_ff @(posedge clk) begin
        if (ctr_wr) begin
            ctr_mem[ex_idx] <= ctr_nxt;
        end
        if (tgt_wr) begin
            tgt_mem[ex_idx] <= ex_target;
        end
        if (alloc) begin
            tag_mem[ex_idx] <= ex_tag;
        end
    end

`ifdef PC_BTB_PERF_EN
    // Free-running wrap-around event counters
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_cti_count        <= '0;
            perf_mispredict_count <= '0;
        end else begin
            if (ex_valid && ex_is_cti) begin
                perf_cti_count <= perf_cti_count + 32'd1;
            end
            if (flush) begin
                perf_mispredict_count <= perf_mispredict_count + 32'd1;
            end
        end
    end
`else
    assign perf_cti_count        = '0;
    assign perf_mispredict_count = '0;
`endif

endmodule

// File: tb/tb_pc_btb_unit.sv
// Directed self-checking bench for pc_btb_unit (default parameters).
module tb_pc_btb_unit;

    logic        clk;
    logic        rst;
    logic        trigger;
    logic        stall_f;
    logic        ex_valid;
    logic        ex_is_cti;
    logic        ex_taken;
    logic [31:0] ex_pc;
    logic [31:0] ex_target;
    logic        ex_pred_taken;
    logic [31:0] ex_pred_target;
    logic [31:0] pc;
    logic [31:0] pcplus4;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        flush;
    logic [31:0] perf_cti_count;
    logic [31:0] perf_mispredict_count;

    int checks;
    int passed;

    pc_btb_unit dut (
        .clk                   (clk),
        .rst                   (rst),
        .trigger               (trigger),
        .stall_f               (stall_f),
        .ex_valid              (ex_valid),
        .ex_is_cti             (ex_is_cti),
        .ex_taken              (ex_taken),
        .ex_pc                 (ex_pc),
        .ex_target             (ex_target),
        .ex_pred_taken         (ex_pred_taken),
        .ex_pred_target        (ex_pred_target),
        .pc                    (pc),
        .pcplus4               (pcplus4),
        .pred_taken            (pred_taken),
        .pred_target           (pred_target),
        .flush                 (flush),
        .perf_cti_count        (perf_cti_count),
        .perf_mispredict_count (perf_mispredict_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ex(input logic cti, input logic tk, input logic [31:0] epc,
                          input logic [31:0] tgt, input logic ptk, input logic [31:0] ptgt);
        ex_valid       = 1'b1;
        ex_is_cti      = cti;
        ex_taken       = tk;
        ex_pc          = epc;
        ex_target      = tgt;
        ex_pred_taken  = ptk;
        ex_pred_target = ptgt;
    endtask

    task automatic clear_ex();
        ex_valid       = 1'b0;
        ex_is_cti      = 1'b0;
        ex_taken       = 1'b0;
        ex_pc          = 32'h0;
        ex_target      = 32'h0;
        ex_pred_taken  = 1'b0;
        ex_pred_target = 32'h0;
    endtask

    // Steer fetch with a wrongly-predicted non-CTI at addr-4 (idx never valid here)
    task automatic goto_pc(input string tag, input logic [31:0] addr);
        set_ex(1'b0, 1'b0, addr - 32'd4, 32'h0, 1'b1, 32'h0);
        #1;
        chk({tag, "_flush"}, 32'(flush), 32'd1);
        tick();
        clear_ex();
        #1;
        chk({tag, "_pc"}, pc, addr);
    endtask

    initial begin
        checks  = 0;
        passed  = 0;
        rst     = 1'b1;
        trigger = 1'b0;
        stall_f = 1'b0;
        clear_ex();

        // 1: reset, hold with trigger low, then sequential fetch
        tick();
        rst = 1'b0;
        chk("rst_pc", pc, 32'h0);
        chk("rst_perf_cti", perf_cti_count, 32'h0);
        chk("rst_perf_mis", perf_mispredict_count, 32'h0);
        for (int i = 0; i < 5; i++) tick();
        chk("trig_low_hold", pc, 32'h0);
        trigger = 1'b1;
        #1;
        chk("seq0_pc", pc, 32'h0);
        chk("seq0_pcplus4", pcplus4, 32'h4);
        chk("seq0_pred", 32'(pred_taken), 32'd0);
        chk("seq0_ptgt", pred_target, 32'h4);
        tick(); chk("seq1_pc", pc, 32'h4);
        chk("seq1_pred", 32'(pred_taken), 32'd0);
        tick(); chk("seq2_pc", pc, 32'h8);
        tick(); chk("seq3_pc", pc, 32'hC);
        chk("seq3_pred", 32'(pred_taken), 32'd0);

        // 2: taken branch 0x10->0x40 mispredicted, allocates ctr=10
        set_ex(1'b1, 1'b1, 32'h10, 32'h40, 1'b0, 32'h14);
        #1;
        chk("br_flush", 32'(flush), 32'd1);
        tick(); clear_ex(); #1;
        chk("br_redir_pc", pc, 32'h40);
        chk("br_flush_clr", 32'(flush), 32'd0);
        goto_pc("g10a", 32'h10);
        chk("hit_pred", 32'(pred_taken), 32'd1);
        chk("hit_ptgt", pred_target, 32'h40);
        // correctly predicted taken: no flush, follow prediction, ctr 10->11
        set_ex(1'b1, 1'b1, 32'h10, 32'h40, 1'b1, 32'h40);
        #1;
        chk("okpred_flush", 32'(flush), 32'd0);
        tick(); clear_ex();
        chk("okpred_pc", pc, 32'h40);

        // 3: hysteresis; not-taken 11->10 still predicts taken
        set_ex(1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 32'h40);
        #1;
        chk("nt1_flush", 32'(flush), 32'd1);
        tick(); clear_ex();
        chk("nt1_pc", pc, 32'h14);
        goto_pc("g10b", 32'h10);
        chk("ctr10_pred", 32'(pred_taken), 32'd1);
        set_ex(1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 32'h40);
        #1;
        chk("nt2_flush", 32'(flush), 32'd1);
        tick(); clear_ex();
        chk("nt2_pc", pc, 32'h14);
        goto_pc("g10c", 32'h10);
        chk("ctr01_pred", 32'(pred_taken), 32'd0);
        chk("ctr01_ptgt", pred_target, 32'h14);

        // 4: raise ctr to 10, then alias at 0x50 and invalidate via non-CTI
        set_ex(1'b1, 1'b1, 32'h10, 32'h40, 1'b0, 32'h14);
        tick(); clear_ex();
        chk("up_pc", pc, 32'h40);
        goto_pc("g10d", 32'h10);
        chk("up_pred", 32'(pred_taken), 32'd1);
        goto_pc("g50", 32'h50);
        chk("alias_pred", 32'(pred_taken), 32'd0);
        chk("alias_ptgt", pred_target, 32'h54);
        set_ex(1'b0, 1'b0, 32'h10, 32'h0, 1'b1, 32'h40);
        #1;
        chk("inv_flush", 32'(flush), 32'd1);
        tick(); clear_ex();
        chk("inv_pc", pc, 32'h14);
        goto_pc("g10e", 32'h10);
        chk("inv_pred", 32'(pred_taken), 32'd0);

        // 5: mispredict overrides stall and trigger low; otherwise hold
        stall_f = 1'b1;
        set_ex(1'b1, 1'b1, 32'h30, 32'h80, 1'b0, 32'h34);
        tick(); clear_ex();
        chk("stall_redir_pc", pc, 32'h80);
        tick();
        chk("stall_hold_pc", pc, 32'h80);
        stall_f = 1'b0;
        trigger = 1'b0;
        goto_pc("trig_redir", 32'h10);
        tick();
        chk("trig_hold_pc", pc, 32'h10);
        trigger = 1'b1;
        goto_pc("g30", 32'h30);
        chk("stall_upd_pred", 32'(pred_taken), 32'd1);
        chk("stall_upd_ptgt", pred_target, 32'h80);

        // wrap-around of pc+4 and ex_pc+4
        goto_pc("gmax", 32'hFFFF_FFFC);
        chk("wrap_pcplus4", pcplus4, 32'h0);
        chk("wrap_ptgt", pred_target, 32'h0);
        tick();
        chk("wrap_pc", pc, 32'h0);
        goto_pc("gwrap", 32'h0);

        // 6: mid-run reset empties the BTB
        set_ex(1'b1, 1'b1, 32'h10, 32'h40, 1'b0, 32'h14);
        tick(); clear_ex();
        goto_pc("g10f", 32'h10);
        chk("pop_pred", 32'(pred_taken), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst2_pc", pc, 32'h0);
        chk("rst2_perf_cti", perf_cti_count, 32'h0);
        chk("rst2_perf_mis", perf_mispredict_count, 32'h0);
        goto_pc("g10g", 32'h10);
        chk("rst2_pred", 32'(pred_taken), 32'd0);
        chk("rst2_g30_pc", pc, 32'h10);

        // perf: 3 CTIs, 2 flushes since reset (goto above is flush #1)
        set_ex(1'b1, 1'b1, 32'h10, 32'h40, 1'b1, 32'h40);
        tick();
        chk("pf_cti1_pc", pc, 32'h14);
        tick();
        chk("pf_cti2_pc", pc, 32'h18);
        set_ex(1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 32'h40);
        tick(); clear_ex();
        chk("pf_cti3_pc", pc, 32'h14);
`ifdef PC_BTB_PERF_EN
        chk("perf_cti", perf_cti_count, 32'd3);
        chk("perf_mis", perf_mispredict_count, 32'd2);
`else
        chk("perf_cti_off", perf_cti_count, 32'd0);
        chk("perf_mis_off", perf_mispredict_count, 32'd0);
`endif
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst3_pc", pc, 32'h0);
        chk("rst3_perf_cti", perf_cti_count, 32'h0);
        chk("rst3_perf_mis", perf_mispredict_count, 32'h0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
